fp_mul_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational single-precision `Floating_mul` instance among `N_REQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The block registers the winning operands, runs them through the multiplier, captures the product, and returns it to the granted requester with a valid/ready response handshake. It sits between the FP-using clients and the multiplier, so no client drives the multiplier directly.

---
 rtl/fp_mul_pkg.sv | 16 +
 rtl/fp_mul_arbiter_if.sv | 31 +++
 rtl/fp_mul_arbiter_floating_mul.sv | 69 ++++++
 rtl/fp_mul_arbiter.sv | 127 ++++++++++++
 tb/tb_fp_mul_arbiter.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the FP multiplier arbiter slice.
package fp_mul_pkg;

    typedef logic [31:0] fp32_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } fpm_state_e;

    localparam fp32_t FP_ZERO = 32'h0000_0000;
    localparam fp32_t FP_ONE  = 32'h3f80_0000;
    localparam fp32_t FP_INF  = 32'h7f80_0000;

endpackage

// File: rtl/fp_mul_arbiter_if.sv
// Requester-side bundle: operand request handshake, product response
// handshake and arbiter status.
interface fp_mul_arbiter_if
    import fp_mul_pkg::*;
#(
    parameter int N_REQ = 4
);

    logic  [N_REQ-1:0]         req_valid;
    fp32_t [N_REQ-1:0]         req_a;
    fp32_t [N_REQ-1:0]         req_b;
    logic  [N_REQ-1:0]         req_ready;
    logic  [N_REQ-1:0]         resp_valid;
    fp32_t                     resp_y;
    logic  [N_REQ-1:0]         resp_ready;
    logic                      busy;
    logic  [$clog2(N_REQ)-1:0] grant_id;

    // Arbiter side
    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_y, busy, grant_id
    );

    // Requester side
    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_y, busy, grant_id
    );

endinterface

// File: rtl/fp_mul_arbiter_floating_mul.sv
// Combinational IEEE-754 single-precision multiplier. Subnormal inputs are
// treated as zero, results round to nearest-even, overflow saturates to
// infinity and underflow flushes to signed zero.
module Floating_mul
    import fp_mul_pkg::*;
(
    input  fp32_t a,
    input  fp32_t b,
    output fp32_t y
);

    logic        sy_s;
    logic [7:0]  ea_s;
    logic [7:0]  eb_s;
    logic        a_nan_s, b_nan_s, a_inf_s, b_inf_s, a_zero_s, b_zero_s;
    logic [47:0] prod_s;
    logic signed [9:0] exp_s;
    logic [22:0] mant_s;
    logic        guard_s;
    logic        sticky_s;
    logic [23:0] rnd_s;

    assign sy_s     = a[31] ^ b[31];
    assign ea_s     = a[30:23];
    assign eb_s     = b[30:23];
    assign a_nan_s  = (ea_s == 8'hff) && (a[22:0] != 23'd0);
    assign b_nan_s  = (eb_s == 8'hff) && (b[22:0] != 23'd0);
    assign a_inf_s  = (ea_s == 8'hff) && (a[22:0] == 23'd0);
    assign b_inf_s  = (eb_s == 8'hff) && (b[22:0] == 23'd0);
    assign a_zero_s = (ea_s == 8'h00);
    assign b_zero_s = (eb_s == 8'h00);

    // Significand product, normalisation, rounding and special-case selection
    always_comb begin
        prod_s = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        exp_s  = $signed({2'b00, ea_s}) + $signed({2'b00, eb_s}) - 10'sd127;
        if (prod_s[47]) begin
            mant_s   = prod_s[46:24];
            guard_s  = prod_s[23];
            sticky_s = |prod_s[22:0];
            exp_s    = exp_s + 10'sd1;
        end else begin
            mant_s   = prod_s[45:23];
            guard_s  = prod_s[22];
            sticky_s = |prod_s[21:0];
        end
        rnd_s = {1'b0, mant_s} + {23'd0, guard_s & (sticky_s | mant_s[0])};
        if (rnd_s[23]) begin
            exp_s = exp_s + 10'sd1;
        end else begin
            exp_s = exp_s;
        end

        if (a_nan_s || b_nan_s || (a_inf_s && b_zero_s) || (a_zero_s && b_inf_s)) begin
            y = 32'h7fc0_0000;
        end else if (a_inf_s || b_inf_s) begin
            y = {sy_s, FP_INF[30:0]};
        end else if (a_zero_s || b_zero_s) begin
            y = {sy_s, FP_ZERO[30:0]};
        end else if (exp_s >= 10'sd255) begin
            y = {sy_s, FP_INF[30:0]};
        end else if (exp_s <= 10'sd0) begin
            y = {sy_s, FP_ZERO[30:0]};
        end else begin
            y = {sy_s, exp_s[7:0], rnd_s[22:0]};
        end
    end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one Floating_mul among N_REQ requesters.
// One transaction in flight: IDLE (grant) -> EXEC (multiply) -> RESP (return).
module fp_mul_arbiter
    import fp_mul_pkg::*;
#(
    parameter int N_REQ = 4
)(
    input  logic              clk,
    input  logic              rst_n,
    fp_mul_arbiter_if.slave   bus
);

    localparam int IDW = $clog2(N_REQ);

    typedef struct packed {
        logic           found;
        logic [IDW-1:0] idx;
    } pick_t;

    // First valid requester after `last`, wrapping modulo N_REQ. Scanning
    // from the farthest candidate down lets the nearest one overwrite.
    function automatic pick_t rr_pick(input logic [N_REQ-1:0] valid,
                                      input logic [IDW-1:0]   last);
        pick_t          p;
        logic [IDW-1:0] cand;
        p.found = 1'b0;
        p.idx   = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = IDW'((int'(last) + k) % N_REQ);
            if (valid[cand]) begin
                p.found = 1'b1;
                p.idx   = cand;
            end
        end
        return p;
    endfunction

    fpm_state_e     state_r, state_next_s;
    logic [IDW-1:0] last_grant_r;
    logic [IDW-1:0] grant_id_r;
    fp32_t          op_a_r, op_b_r, result_r;
    fp32_t          mul_y_s;
    logic           busy_r;
    pick_t          pick_s;
    logic [N_REQ-1:0] req_ready_s;
    logic [N_REQ-1:0] resp_valid_s;

    assign pick_s = rr_pick(bus.req_valid, last_grant_r);

    Floating_mul u_mul (
        .a (op_a_r),
        .b (op_b_r),
        .y (mul_y_s)
    );

    // Next-state selection for the grant/execute/respond sequence
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (pick_s.found) state_next_s = EXEC;
                else              state_next_s = IDLE;
            end
            EXEC: state_next_s = RESP;
            RESP: begin
                if (bus.resp_ready[grant_id_r]) state_next_s = IDLE;
                else                            state_next_s = RESP;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Grant is combinational so the winner sees ready in its valid cycle;
    // held at zero while reset is asserted.
    always_comb begin
        req_ready_s = '0;
        if (rst_n && (state_r == IDLE) && pick_s.found) begin
            req_ready_s[pick_s.idx] = 1'b1;
        end else begin
            req_ready_s = '0;
        end
    end

    // Response strobe goes only to the granted requester
    always_comb begin
        resp_valid_s = '0;
        if (state_r == RESP) begin
            resp_valid_s[grant_id_r] = 1'b1;
        end else begin
            resp_valid_s = '0;
        end
    end

    // State, captured operands/result, grant bookkeeping and busy flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            last_grant_r <= IDW'(N_REQ - 1);
            grant_id_r   <= '0;
            op_a_r       <= FP_ZERO;
            op_b_r       <= FP_ZERO;
            result_r     <= FP_ZERO;
            busy_r       <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != IDLE);
            if ((state_r == IDLE) && pick_s.found) begin
                op_a_r     <= bus.req_a[pick_s.idx];
                op_b_r     <= bus.req_b[pick_s.idx];
                grant_id_r <= pick_s.idx;
            end
            if (state_r == EXEC) begin
                result_r <= mul_y_s;
            end
            if ((state_r == RESP) && bus.resp_ready[grant_id_r]) begin
                last_grant_r <= grant_id_r;
            end
        end
    end

    assign bus.req_ready  = req_ready_s;
    assign bus.resp_valid = resp_valid_s;
    assign bus.resp_y     = result_r;
    assign bus.busy       = busy_r;
    assign bus.grant_id   = grant_id_r;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Self-checking bench for fp_mul_arbiter: directed scenarios plus randomized
// transactions compared against a transaction-level reference model.
module tb_fp_mul_arbiter;
    import fp_mul_pkg::*;

    localparam int N = 4;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    int   model_last;

    fp32_t op_a_m [N];
    fp32_t op_b_m [N];

    fp_mul_arbiter_if #(.N_REQ(N)) bus ();

    fp_mul_arbiter #(.N_REQ(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int rr_model(input logic [N-1:0] mask, input int last);
        for (int k = 1; k <= N; k++) begin
            if (mask[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic bit is_inf(input fp32_t x);
        return (x[30:23] == 8'hff) && (x[22:0] == 23'd0);
    endfunction

    function automatic bit is_zero(input fp32_t x);
        return x[30:0] == 31'd0;
    endfunction

    function automatic real to_real(input fp32_t x);
        logic [63:0] d;
        d = {x[31], 11'(int'(x[30:23]) - 127 + 1023), x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    // Operands are built so that the exact product fits in single precision
    function automatic fp32_t model_mul(input fp32_t a, input fp32_t b);
        logic        s;
        logic [63:0] d;
        int          e;
        s = a[31] ^ b[31];
        if (is_inf(a) || is_inf(b)) return {s, 8'hff, 23'd0};
        if (is_zero(a) || is_zero(b)) return {s, 31'd0};
        d = $realtobits(to_real(a) * to_real(b));
        e = int'(d[62:52]) - 1023 + 127;
        return {d[63], 8'(e), d[51:29]};
    endfunction

    function automatic fp32_t gen_op();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return {1'($urandom), 31'd0};
        if (r == 1) return {1'($urandom), 8'hff, 23'd0};
        return {1'($urandom), 8'($urandom_range(100, 154)), 8'($urandom), 15'd0};
    endfunction

    task automatic gen_pair(input int i);
        op_a_m[i] = gen_op();
        op_b_m[i] = gen_op();
        if ((is_inf(op_a_m[i]) && is_zero(op_b_m[i])) || (is_zero(op_a_m[i]) && is_inf(op_b_m[i])))
            op_b_m[i] = FP_ONE;
    endtask

    task automatic drive_ops();
        for (int i = 0; i < N; i++) begin
            bus.req_a[i] = op_a_m[i];
            bus.req_b[i] = op_b_m[i];
        end
    endtask

    // One full transaction; entered and left at posedge+1 of an IDLE cycle.
    task automatic run_txn(input logic [N-1:0] mask, input logic [N-1:0] busy_mask,
                           input int stall, output int obs_w, output fp32_t obs_y);
        int         exp_w;
        fp32_t      exp_y;
        logic [N-1:0] oh;
        exp_w = rr_model(mask, model_last);
        exp_y = model_mul(op_a_m[exp_w], op_b_m[exp_w]);
        oh    = N'(1) << exp_w;
        drive_ops();
        bus.req_valid  = mask;
        bus.resp_ready = '0;
        @(negedge clk);
        check_eq("idle_req_ready", 32'(bus.req_ready), 32'(oh));
        check_eq("idle_busy", 32'(bus.busy), 32'd0);
        check_eq("idle_resp_valid", 32'(bus.resp_valid), 32'd0);
        @(posedge clk); #1;
        bus.req_valid = busy_mask;
        for (int i = 0; i < N; i++) begin
            bus.req_a[i] = $urandom;
            bus.req_b[i] = $urandom;
        end
        @(negedge clk);
        check_eq("exec_req_ready", 32'(bus.req_ready), 32'd0);
        check_eq("exec_busy", 32'(bus.busy), 32'd1);
        check_eq("exec_grant_id", 32'(bus.grant_id), 32'(exp_w));
        check_eq("exec_resp_valid", 32'(bus.resp_valid), 32'd0);
        obs_w = int'(bus.grant_id);
        @(posedge clk); #1;
        obs_y = bus.resp_y;
        for (int s = 0; s <= stall; s++) begin
            bus.resp_ready = N'($urandom) & ~oh;
            if (s == stall) bus.resp_ready = bus.resp_ready | oh;
            @(negedge clk);
            check_eq("resp_valid", 32'(bus.resp_valid), 32'(oh));
            check_eq("resp_y", bus.resp_y, exp_y);
            check_eq("resp_busy", 32'(bus.busy), 32'd1);
            check_eq("resp_req_ready", 32'(bus.req_ready), 32'd0);
            @(posedge clk); #1;
        end
        bus.resp_ready = '0;
        model_last = exp_w;
    endtask

    initial begin
        int    w;
        fp32_t y;
        n_tests = 0;
        n_fail  = 0;
        model_last = N - 1;
        bus.req_valid  = '1;
        bus.resp_ready = '0;
        for (int i = 0; i < N; i++) begin
            op_a_m[i] = FP_ZERO;
            op_b_m[i] = FP_ZERO;
        end
        drive_ops();

        // Reset values, with every requester asking
        rst_n = 1'b0;
        #12;
        check_eq("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check_eq("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_grant_id", 32'(bus.grant_id), 32'd0);
        bus.req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // No request: stays idle
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check_eq("noreq_ready", 32'(bus.req_ready), 32'd0);
            check_eq("noreq_busy", 32'(bus.busy), 32'd0);
            @(posedge clk); #1;
        end

        // Single request
        op_a_m[0] = 32'h3fc0_0000;
        op_b_m[0] = 32'h4000_0000;
        run_txn(4'b0001, 4'b0000, 0, w, y);
        check_eq("single_grant", 32'(w), 32'd0);
        check_eq("single_y", y, 32'h4040_0000);

        // Round-robin order after a fresh reset
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        model_last = N - 1;
        @(posedge clk); #1;
        op_a_m[0] = 32'h4040_0000; op_b_m[0] = FP_ONE;
        op_a_m[1] = FP_ONE;        op_b_m[1] = FP_ONE;
        op_a_m[2] = FP_ZERO;       op_b_m[2] = FP_ONE;
        op_a_m[3] = FP_INF;        op_b_m[3] = FP_ONE;
        begin
            logic [31:0] rr_exp [N];
            rr_exp[0] = 32'h4040_0000;
            rr_exp[1] = 32'h3f80_0000;
            rr_exp[2] = 32'h0000_0000;
            rr_exp[3] = 32'h7f80_0000;
            for (int k = 0; k < N; k++) begin
                run_txn(4'b1111, 4'b1111, 0, w, y);
                check_eq("rr_grant", 32'(w), 32'(k));
                check_eq("rr_y", y, rr_exp[k]);
            end
        end

        // Backpressure on requester 1 while 0 and 2 wait
        op_a_m[1] = 32'h4000_0000; op_b_m[1] = 32'h4000_0000;
        run_txn(4'b0010, 4'b0101, 5, w, y);
        check_eq("bp_grant", 32'(w), 32'd1);
        check_eq("bp_y", y, 32'h4080_0000);
        run_txn(4'b0101, 4'b0101, 0, w, y);
        check_eq("bp_next_grant", 32'(w), 32'd2);

        // Fairness: 0 and 2 continuously valid
        for (int k = 0; k < 4; k++) begin
            run_txn(4'b0101, 4'b0101, 0, w, y);
            check_eq("fair_grant", 32'(w), (k % 2 == 0) ? 32'd0 : 32'd2);
        end

        // Reset while in EXEC
        drive_ops();
        bus.req_valid = 4'b0100;
        @(negedge clk);
        check_eq("rexec_ready", 32'(bus.req_ready), 32'h4);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check_eq("rexec_req_ready", 32'(bus.req_ready), 32'd0);
        check_eq("rexec_busy", 32'(bus.busy), 32'd0);
        check_eq("rexec_grant_id", 32'(bus.grant_id), 32'd0);
        check_eq("rexec_resp_valid", 32'(bus.resp_valid), 32'd0);
        bus.req_valid = '0;
        #2;
        rst_n = 1'b1;
        model_last = N - 1;
        @(posedge clk); #1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq("rexec_no_resp", 32'(bus.resp_valid), 32'd0);
            check_eq("rexec_idle", 32'(bus.busy), 32'd0);
            @(posedge clk); #1;
        end
        op_a_m[3] = 32'h4040_0000; op_b_m[3] = 32'hc000_0000;
        run_txn(4'b1000, 4'b0000, 0, w, y);
        check_eq("rexec_r3_grant", 32'(w), 32'd3);
        check_eq("rexec_r3_y", y, 32'hc0c0_0000);

        // Late valid drop by requester 1 while requester 0 is served
        run_txn(4'b0001, 4'b0010, 1, w, y);
        check_eq("drop_grant", 32'(w), 32'd0);
        bus.req_valid = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_eq("drop_req_ready", 32'(bus.req_ready), 32'd0);
            check_eq("drop_resp_valid", 32'(bus.resp_valid), 32'd0);
            check_eq("drop_busy", 32'(bus.busy), 32'd0);
            @(posedge clk); #1;
        end

        // Randomized transactions
        for (int t = 0; t < 60; t++) begin
            logic [N-1:0] m;
            for (int i = 0; i < N; i++) gen_pair(i);
            m = N'($urandom_range(1, (1 << N) - 1));
            run_txn(m, N'($urandom), $urandom_range(0, 3), w, y);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
